// File: rtl/exu_multicycle.sv
// exu_multicycle: ALU plus iterative mul/divu execute stage with valid/ready on both sides.
// Define EXU_MUL_EARLY_EXIT_EN to let mul finish as soon as the remaining multiplier bits are zero.
module exu_multicycle #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] aluSrc1,
    input  logic [DATA_WIDTH-1:0] aluSrc2,
    input  logic [9:0]            aluOp,
    input  logic                  d_regW,
    input  logic [ADDR_WIDTH-1:0] d_regAddr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  e_regW,
    output logic [ADDR_WIDTH-1:0] e_regAddr,
    output logic [DATA_WIDTH-1:0] e_regData,
    output logic                  busy
);
    localparam int CW = SHAMT_WIDTH + 1;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;
    stateT state;
    logic [CW-1:0] cnt;
    logic [DATA_WIDTH-1:0] acc, opA, opB, data, aluRes, sraRes, mulSum, remNext, quoNext;
    logic [DATA_WIDTH:0] trial;
    logic [SHAMT_WIDTH-1:0] shamt;
    logic [ADDR_WIDTH-1:0] regAddr;
    logic regW, accept, lastIter, mulDone;
    assign shamt = aluSrc2[SHAMT_WIDTH-1:0];
    assign sraRes = $signed(aluSrc1) >>> shamt;
    assign aluRes = ({DATA_WIDTH{aluOp[0]}} & (aluSrc1 + aluSrc2))
                  | ({DATA_WIDTH{aluOp[1]}} & (aluSrc1 - aluSrc2))
                  | ({DATA_WIDTH{aluOp[2]}} & (aluSrc1 & aluSrc2))
                  | ({DATA_WIDTH{aluOp[3]}} & (aluSrc1 | aluSrc2))
                  | ({DATA_WIDTH{aluOp[4]}} & (aluSrc1 ^ aluSrc2))
                  | ({DATA_WIDTH{aluOp[5]}} & (aluSrc1 << shamt))
                  | ({DATA_WIDTH{aluOp[6]}} & (aluSrc1 >> shamt))
                  | ({DATA_WIDTH{aluOp[7]}} & sraRes);
    assign in_ready = state == IDLE || (state == DONE && out_ready);
    assign accept = in_valid && in_ready;
    assign lastIter = cnt == CW'(1);
    // mul: acc accumulates, opA is the shifting multiplicand, opB the shifting multiplier
    assign mulSum = acc + (opB[0] ? opA : '0);
`ifdef EXU_MUL_EARLY_EXIT_EN
    assign mulDone = lastIter || opB[DATA_WIDTH-1:1] == '0;
`else
    assign mulDone = lastIter;
`endif
    // divu: acc is the partial remainder, opA shifts dividend bits out and quotient bits in
    assign trial = {acc, opA[DATA_WIDTH-1]} - {1'b0, opB};
    assign remNext = trial[DATA_WIDTH] ? {acc[DATA_WIDTH-2:0], opA[DATA_WIDTH-1]} : trial[DATA_WIDTH-1:0];
    assign quoNext = {opA[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
    assign out_valid = state == DONE;
    assign busy = state == MUL || state == DIV;
    assign e_regW = regW && out_valid;
    assign e_regAddr = regAddr;
    assign e_regData = data;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            acc <= '0;
            opA <= '0;
            opB <= '0;
            data <= '0;
            regW <= 1'b0;
            regAddr <= '0;
        end else begin
            case (state)
                MUL: begin
                    cnt <= cnt - CW'(1);
                    acc <= mulSum;
                    opA <= opA << 1;
                    opB <= opB >> 1;
                    if (mulDone) begin
                        data <= mulSum;
                        state <= DONE;
                    end
                end
                DIV: begin
                    cnt <= cnt - CW'(1);
                    acc <= remNext;
                    opA <= quoNext;
                    if (lastIter) begin
                        data <= quoNext;
                        state <= DONE;
                    end
                end
                default: begin
                    if (accept) begin
                        cnt <= CW'(DATA_WIDTH);
                        acc <= '0;
                        opA <= aluSrc1;
                        opB <= aluSrc2;
                        regW <= d_regW;
                        regAddr <= d_regAddr;
                        state <= aluOp[9] ? DIV : aluOp[8] ? MUL : DONE;
                        if (!aluOp[9] && !aluOp[8]) data <= aluRes;
                    end else if (out_ready) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
